pwm_frame_sequencer: RTL and testbench

Stereo sample scheduler that feeds the two 7-bit PWM down-counter channels of the audio DAC path. The CPU/DSP pushes packed left/right samples into a small FIFO; the sequencer runs a fixed-length frame timer on XCK and, once per frame, pops one sample pair and issues the active-low load strobe plus data to each PWM counter. It also handles underrun (repeat last sample), overrun and clean start/stop.

---
 rtl/pwm_seq_pkg.sv | 19 +
 rtl/sample_fifo.sv | 53 +++++
 rtl/pwm_frame_sequencer.sv | 118 +++++++++++
 tb/tb_pwm_frame_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the stereo PWM frame sequencer.
// Mid-scale, minimum frame length, sequencer states and sample-pair layout.
package pwm_seq_pkg;

   localparam logic [6:0] MIDSCALE      = 7'h40;
   localparam int         FRAME_LEN_MIN = 128;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } seq_state_t;

   typedef struct packed {
      logic [6:0] right;
      logic [6:0] left;
   } sample_pair_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding packed left/right sample pairs.
// Occupancy is kept as a register so full/empty are glitch-free.
module sample_fifo #(
   parameter int W     = 14,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          XCK,
   input  logic          RESET,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   occ
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          do_wr;
   logic          do_rd;

   assign full    = occ == (AW+1)'(DEPTH);
   assign empty   = occ == '0;
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rp];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge XCK) begin
      if (do_wr) mem[wp] <= wr_data;
   end

   // Pointers and occupancy; simultaneous write and read leaves occ unchanged.
   always_ff @(posedge XCK or posedge RESET) begin
      if (RESET) begin
         wp  <= '0;
         rp  <= '0;
         occ <= '0;
      end else begin
         if (do_wr) wp <= wp + AW'(1);
         if (do_rd) rp <= rp + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pwm_frame_sequencer.sv
// Per-frame stereo sample scheduler feeding two 7-bit PWM down-counters.
// Pops one pair per frame, strobes active-low loads, flags under/overrun.
module pwm_frame_sequencer
   import pwm_seq_pkg::*;
#(
   parameter int FRAME_LEN  = 128,
   parameter int FIFO_DEPTH = 4,
   parameter int DW         = 7
) (
   input  logic            XCK,
   input  logic            RESET,
   input  logic            ENA,
   input  logic            WR,
   input  logic [2*DW-1:0] WD,
   output logic            FULL,
   output logic            REQ,
   output logic            LDL_L,
   output logic [DW-1:0]   D_L,
   output logic            LDL_R,
   output logic [DW-1:0]   D_R,
   output logic            UNDER,
   output logic            OVER,
   input  logic            CLRFLG
);

   localparam int FL = (FRAME_LEN < FRAME_LEN_MIN) ? FRAME_LEN_MIN
                                                  : FRAME_LEN;
   localparam int CW = $clog2(FL);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [DW-1:0] MID = DW'(1) << (DW - 1);

   seq_state_t      state;
   logic [CW-1:0]   cnt;
   logic [2*DW-1:0] hold;
   logic [2*DW-1:0] fifo_q;
   logic [2*DW-1:0] nxt_hold;
   logic [AW:0]     occ;
   logic            fifo_full;
   logic            fifo_empty;
   logic            pop;
   logic            last;
   logic            under_ev;
   logic            over_ev;

   sample_fifo #(
      .W     (2*DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .XCK     (XCK),
      .RESET   (RESET),
      .wr_en   (WR),
      .wr_data (WD),
      .rd_en   (pop),
      .rd_data (fifo_q),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .occ     (occ)
   );

   assign pop      = (state == RUN) && (cnt == '0);
   assign last     = cnt == CW'(FL - 1);
   assign under_ev = pop & fifo_empty;
   assign over_ev  = WR & fifo_full;
   assign nxt_hold = fifo_empty ? hold : fifo_q;
   assign FULL     = fifo_full;
   assign REQ      = occ < (AW+1)'(FIFO_DEPTH / 2);

   // Sequencer: frame counter, sample hold and registered load strobes.
   always_ff @(posedge XCK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         cnt   <= '0;
         hold  <= {MID, MID};
         LDL_L <= 1'b1;
         LDL_R <= 1'b1;
         D_L   <= MID;
         D_R   <= MID;
      end else begin
         LDL_L <= 1'b1;
         LDL_R <= 1'b1;
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (ENA) state <= RUN;
            end
            RUN: begin
               cnt <= last ? '0 : cnt + CW'(1);
               if (cnt == '0) begin
                  hold  <= nxt_hold;
                  D_L   <= nxt_hold[DW-1:0];
                  D_R   <= nxt_hold[2*DW-1:DW];
                  LDL_L <= 1'b0;
                  LDL_R <= 1'b0;
               end
               if (!ENA) state <= last ? IDLE : DRAIN;
            end
            DRAIN: begin
               cnt <= last ? '0 : cnt + CW'(1);
               if (ENA)       state <= RUN;
               else if (last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky flags; a new event in the clear cycle keeps the flag set.
   always_ff @(posedge XCK or posedge RESET) begin
      if (RESET) begin
         UNDER <= 1'b0;
         OVER  <= 1'b0;
      end else begin
         UNDER <= (UNDER & ~CLRFLG) | under_ev;
         OVER  <= (OVER & ~CLRFLG) | over_ev;
      end
   end

endmodule

// File: tb/tb_pwm_frame_sequencer.sv
// Scoreboard bench for pwm_frame_sequencer with a frame-level reference model.
// Stimulus pushes expected loads; a negedge monitor pops and compares them.
module tb_pwm_frame_sequencer;
   import pwm_seq_pkg::*;

   localparam int FL    = 128;
   localparam int DEPTH = 4;

   logic        XCK = 1'b0;
   logic        RESET;
   logic        ENA = 1'b0;
   logic        WR = 1'b0;
   logic [13:0] WD = '0;
   logic        CLRFLG = 1'b0;
   logic        FULL;
   logic        REQ;
   logic        LDL_L;
   logic [6:0]  D_L;
   logic        LDL_R;
   logic [6:0]  D_R;
   logic        UNDER;
   logic        OVER;

   pwm_frame_sequencer #(
      .FRAME_LEN  (FL),
      .FIFO_DEPTH (DEPTH),
      .DW         (7)
   ) dut (
      .XCK    (XCK),
      .RESET  (RESET),
      .ENA    (ENA),
      .WR     (WR),
      .WD     (WD),
      .FULL   (FULL),
      .REQ    (REQ),
      .LDL_L  (LDL_L),
      .D_L    (D_L),
      .LDL_R  (LDL_R),
      .D_R    (D_R),
      .UNDER  (UNDER),
      .OVER   (OVER),
      .CLRFLG (CLRFLG)
   );

   always #5 XCK = ~XCK;

   int cyc = 0;
   always @(posedge XCK) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int           t;
      sample_pair_t v;
   } load_t;

   load_t        scb[$];
   logic [13:0]  mq[$];
   sample_pair_t hold_m = {MIDSCALE, MIDSCALE};
   sample_pair_t last_v = {MIDSCALE, MIDSCALE};
   load_t        e;
   bit           active = 0;
   bit           ena_prev = 0;
   bit           exp_under = 0;
   bit           exp_over = 0;
   int           run_from = 0;

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cyc %0d",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: every cycle, strobes must match the scoreboard and data
   // must either be the expected load or the previously loaded pair.
   always @(negedge XCK) begin
      bit exp_ld;
      if (RESET) begin
         last_v = {MIDSCALE, MIDSCALE};
      end else begin
         exp_ld = (scb.size() > 0) && (scb[0].t == cyc);
         check("ldl_l", LDL_L, !exp_ld);
         check("ldl_r", LDL_R, !exp_ld);
         if (exp_ld) begin
            e = scb.pop_front();
            check("load_d_l", D_L, e.v.left);
            check("load_d_r", D_R, e.v.right);
            last_v = e.v;
         end else begin
            check("stable_d_l", D_L, last_v.left);
            check("stable_d_r", D_R, last_v.right);
         end
      end
   end

   // One cycle of stimulus plus the frame-level model of that cycle.
   // A frame begins every FL cycles from the first RUN cycle; its load
   // happens only if playback was enabled in the previous cycle, and
   // playback stops at a frame end when ENA is low.
   task automatic step(bit wr, logic [13:0] wd, bit ena, bit clr);
      bit full_m;
      bit uev;
      bit oev;
      int ph;
      WR     = wr;
      WD     = wd;
      ENA    = ena;
      CLRFLG = clr;
      full_m = mq.size() == DEPTH;
      uev    = 0;
      oev    = wr && full_m;
      if (active) begin
         ph = (cyc - run_from) % FL;
         if (ph == 0 && ena_prev) begin
            if (mq.size() > 0) hold_m = mq.pop_front();
            else uev = 1;
            scb.push_back('{cyc + 1, hold_m});
         end
         if (ph == FL - 1 && !ena) active = 0;
      end else if (ena) begin
         active   = 1;
         run_from = cyc + 1;
      end
      if (wr && !full_m) mq.push_back(wd);
      exp_under = (exp_under && !clr) || uev;
      exp_over  = (exp_over && !clr) || oev;
      ena_prev  = ena;
      @(posedge XCK);
      #1;
      check("under", UNDER, exp_under);
      check("over", OVER, exp_over);
      check("full", FULL, mq.size() == DEPTH);
      check("req", REQ, mq.size() < DEPTH / 2);
   endtask

   task automatic do_reset();
      RESET  = 1'b1;
      WR     = 1'b0;
      ENA    = 1'b0;
      CLRFLG = 1'b0;
      WD     = '0;
      scb.delete();
      mq.delete();
      hold_m    = {MIDSCALE, MIDSCALE};
      active    = 0;
      ena_prev  = 0;
      exp_under = 0;
      exp_over  = 0;
      repeat (2) @(posedge XCK);
      @(negedge XCK);
      RESET = 1'b0;
      @(posedge XCK);
      #1;
   endtask

   function automatic int to_phase(int ph);
      return (((ph - (cyc - run_from)) % FL) + FL) % FL;
   endfunction

   initial begin
      int n;
      int rate;
      bit ena_r;
      #1;
      do_reset();
      check("rst_ldl_l", LDL_L, 1);
      check("rst_ldl_r", LDL_R, 1);
      check("rst_d_l", D_L, 7'h40);
      check("rst_d_r", D_R, 7'h40);
      check("rst_full", FULL, 0);
      check("rst_req", REQ, 1);
      check("rst_under", UNDER, 0);
      check("rst_over", OVER, 0);

      repeat (300) step(0, '0, 0, 0);

      step(1, {7'h70, 7'h10}, 0, 0);
      step(1, {7'h60, 7'h20}, 0, 0);
      repeat (400) step(0, '0, 1, 0);

      n = to_phase(50);
      repeat (n) step(0, '0, 1, 0);
      repeat (50) step(0, '0, 0, 0);
      repeat (300) step(0, '0, 1, 0);

      n = to_phase(50);
      repeat (n) step(0, '0, 1, 0);
      repeat (300) step(0, '0, 0, 0);

      step(0, '0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 14'($urandom), 0, 0);
      step(0, '0, 0, 0);
      step(0, '0, 0, 1);

      step(0, '0, 1, 0);
      n = run_from + 2 * FL - cyc;
      repeat (n) step(0, '0, 1, 0);
      step(1, 14'($urandom), 1, 0);
      repeat (300) step(0, '0, 1, 0);

      ena_r = 1;
      for (int b = 0; b < 6; b++) begin
         rate = (b % 3 == 0) ? 5 : ((b % 3 == 1) ? 10 : 30);
         for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 299) == 0) ena_r = !ena_r;
            step($urandom_range(0, 999) < rate, 14'($urandom), ena_r,
                 $urandom_range(0, 199) == 0);
         end
      end

      do_reset();
      step(1, 14'($urandom), 0, 0);
      step(0, '0, 1, 0);
      step(0, '0, 1, 0);
      check("ldl_low_pre_rst", LDL_L, 0);
      RESET = 1'b1;
      #1;
      check("rst_cut_ldl_l", LDL_L, 1);
      check("rst_cut_ldl_r", LDL_R, 1);
      check("rst_cut_d_l", D_L, 7'h40);
      check("rst_cut_d_r", D_R, 7'h40);
      check("rst_cut_full", FULL, 0);
      check("rst_cut_req", REQ, 1);
      do_reset();
      repeat (200) step(0, '0, 0, 0);
      step(1, {7'h11, 7'h22}, 0, 0);
      repeat (300) step(0, '0, 1, 0);
      repeat (FL + 5) step(0, '0, 0, 0);

      check("scb_empty", scb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
